// File: rtl/iob_axi2iob.sv
// AXI4 slave to IOb master bridge; serves one AXI transaction at a time, one beat per IOb access.
// Latency: AW/AR accepted one cycle after valid is seen; read beats appear one cycle after iob_rvalid_i.
// Backpressure: W passes straight through to IOb (wready = iob_ready); B/R outputs hold until bready/rready.
module iob_axi2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  // AXI write address
  input  logic                  axi_awvalid_i,
  output logic                  axi_awready_o,
  input  logic [ADDR_W-1:0]     axi_awaddr_i,
  input  logic [AXI_ID_W-1:0]   axi_awid_i,
  input  logic [AXI_LEN_W-1:0]  axi_awlen_i,
  input  logic [2:0]            axi_awsize_i,
  input  logic [1:0]            axi_awburst_i,
  // AXI write data
  input  logic                  axi_wvalid_i,
  output logic                  axi_wready_o,
  input  logic [DATA_W-1:0]     axi_wdata_i,
  input  logic [DATA_W/8-1:0]   axi_wstrb_i,
  input  logic                  axi_wlast_i,
  // AXI write response
  output logic                  axi_bvalid_o,
  input  logic                  axi_bready_i,
  output logic [AXI_ID_W-1:0]   axi_bid_o,
  output logic [1:0]            axi_bresp_o,
  // AXI read address
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  input  logic [ADDR_W-1:0]     axi_araddr_i,
  input  logic [AXI_ID_W-1:0]   axi_arid_i,
  input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
  input  logic [2:0]            axi_arsize_i,
  input  logic [1:0]            axi_arburst_i,
  // AXI read data
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  output logic [DATA_W-1:0]     axi_rdata_o,
  output logic [AXI_ID_W-1:0]   axi_rid_o,
  output logic [1:0]            axi_rresp_o,
  output logic                  axi_rlast_o,
  // IOb master
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RD_REQ, RD_WAIT, RD_DATA} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr;
  logic [AXI_ID_W-1:0]    id;
  logic [AXI_LEN_W-1:0]   len;
  logic [2:0]             size;
  logic [1:0]             burst;
  logic [AXI_LEN_W-1:0]   cnt;
  logic                   aw_rdy;
  logic                   ar_rdy;
  logic                   last_rd;   // 1: read won the last contested arbitration
  logic [DATA_W-1:0]      rdata;

  logic                   aw_hs, ar_hs, w_beat, r_beat, beat_last;
  logic [ADDR_W-1:0]      addr_step;

  // Handshake and beat qualifiers; FIXED bursts keep the address, INCR and WRAP step by the beat size
  always_comb begin
    aw_hs     = aw_rdy & axi_awvalid_i;
    ar_hs     = ar_rdy & axi_arvalid_i;
    w_beat    = (state == WRITE) & axi_wvalid_i & iob_ready_i;
    r_beat    = (state == RD_DATA) & axi_rready_i;
    beat_last = (cnt == len);
    addr_step = (burst == 2'b00) ? '0 : (ADDR_W'(1) << size);
  end

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     state <= IDLE;
    else if (cke_i) state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = WRITE;
               else if (ar_hs) state_nxt = RD_REQ;
      WRITE:   if (w_beat && axi_wlast_i) state_nxt = WRESP;
      WRESP:   if (axi_bready_i) state_nxt = IDLE;
      RD_REQ:  if (iob_ready_i) state_nxt = RD_WAIT;
      RD_WAIT: if (iob_rvalid_i) state_nxt = RD_DATA;
      RD_DATA: if (axi_rready_i) state_nxt = beat_last ? IDLE : RD_REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Address-channel grant: ready is registered so it never follows valid combinationally.
  // The round-robin flag only moves on contested grants, so an uncontested grant does not
  // steal the other channel's turn.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      aw_rdy  <= 1'b0;
      ar_rdy  <= 1'b0;
      last_rd <= 1'b0;
    end else if (cke_i) begin
      if (aw_hs) aw_rdy <= 1'b0;
      if (ar_hs) ar_rdy <= 1'b0;
      if (state == IDLE && !aw_rdy && !ar_rdy) begin
        if (axi_awvalid_i && axi_arvalid_i) begin
          if (last_rd) aw_rdy <= 1'b1;
          else         ar_rdy <= 1'b1;
          last_rd <= ~last_rd;
        end else if (axi_awvalid_i) begin
          aw_rdy <= 1'b1;
        end else if (axi_arvalid_i) begin
          ar_rdy <= 1'b1;
        end
      end
    end
  end

  // Transaction context, beat counter/address advance and read data capture
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      addr  <= '0;
      id    <= '0;
      len   <= '0;
      size  <= '0;
      burst <= '0;
      cnt   <= '0;
      rdata <= '0;
    end else if (cke_i) begin
      if (aw_hs) begin
        addr  <= axi_awaddr_i;
        id    <= axi_awid_i;
        len   <= axi_awlen_i;
        size  <= axi_awsize_i;
        burst <= axi_awburst_i;
        cnt   <= '0;
      end else if (ar_hs) begin
        addr  <= axi_araddr_i;
        id    <= axi_arid_i;
        len   <= axi_arlen_i;
        size  <= axi_arsize_i;
        burst <= axi_arburst_i;
        cnt   <= '0;
      end else if (w_beat || r_beat) begin
        addr <= addr + addr_step;
        cnt  <= cnt + 1'b1;
      end
      if (state == RD_WAIT && iob_rvalid_i) rdata <= iob_rdata_i;
    end
  end

  // Outputs decoded from state; data buses are forced to zero outside their active states
  always_comb begin
    axi_awready_o = aw_rdy;
    axi_arready_o = ar_rdy;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_bid_o     = '0;
    axi_bresp_o   = 2'b00;
    axi_rvalid_o  = 1'b0;
    axi_rdata_o   = '0;
    axi_rid_o     = '0;
    axi_rresp_o   = 2'b00;
    axi_rlast_o   = 1'b0;
    iob_valid_o   = 1'b0;
    iob_addr_o    = '0;
    iob_wdata_o   = '0;
    iob_wstrb_o   = '0;
    case (state)
      WRITE: begin
        axi_wready_o = iob_ready_i;
        iob_valid_o  = axi_wvalid_i;
        iob_addr_o   = addr;
        iob_wdata_o  = axi_wdata_i;
        iob_wstrb_o  = axi_wstrb_i;
      end
      WRESP: begin
        axi_bvalid_o = 1'b1;
        axi_bid_o    = id;
      end
      RD_REQ: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = addr;
      end
      RD_DATA: begin
        axi_rvalid_o = 1'b1;
        axi_rdata_o  = rdata;
        axi_rid_o    = id;
        axi_rlast_o  = beat_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_axi2iob.sv
// Bench for iob_axi2iob: AXI master tasks, a randomised IOb slave, and an address/data reference model.
// Latency: none (bench only).
// Backpressure: random IOb ready, random bready delay, rready stalls with clock-enable drops.
`timescale 1ns/1ps
module tb_iob_axi2iob;

  logic        clk = 1'b0;
  logic        cke_i, arst_i;
  logic        axi_awvalid_i, axi_awready_o;
  logic [31:0] axi_awaddr_i;
  logic [0:0]  axi_awid_i;
  logic [7:0]  axi_awlen_i;
  logic [2:0]  axi_awsize_i;
  logic [1:0]  axi_awburst_i;
  logic        axi_wvalid_i, axi_wready_o;
  logic [31:0] axi_wdata_i;
  logic [3:0]  axi_wstrb_i;
  logic        axi_wlast_i;
  logic        axi_bvalid_o, axi_bready_i;
  logic [0:0]  axi_bid_o;
  logic [1:0]  axi_bresp_o;
  logic        axi_arvalid_i, axi_arready_o;
  logic [31:0] axi_araddr_i;
  logic [0:0]  axi_arid_i;
  logic [7:0]  axi_arlen_i;
  logic [2:0]  axi_arsize_i;
  logic [1:0]  axi_arburst_i;
  logic        axi_rvalid_o, axi_rready_i;
  logic [31:0] axi_rdata_o;
  logic [0:0]  axi_rid_o;
  logic [1:0]  axi_rresp_o;
  logic        axi_rlast_o;
  logic        iob_valid_o;
  logic [31:0] iob_addr_o, iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i, iob_rvalid_i;
  logic [31:0] iob_rdata_i;

  iob_axi2iob dut (
    .clk_i(clk), .cke_i(cke_i), .arst_i(arst_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
    .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i), .axi_awsize_i(axi_awsize_i),
    .axi_awburst_i(axi_awburst_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wdata_i(axi_wdata_i),
    .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bid_o(axi_bid_o),
    .axi_bresp_o(axi_bresp_o),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
    .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i), .axi_arsize_i(axi_arsize_i),
    .axi_arburst_i(axi_arburst_i),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .axi_rdata_o(axi_rdata_o),
    .axi_rid_o(axi_rid_o), .axi_rresp_o(axi_rresp_o), .axi_rlast_o(axi_rlast_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } iob_t;

  iob_t        iob_q[$];      // every accepted IOb request, in order
  logic [31:0] exp_r_q[$];    // data the slave returned, in order
  logic [31:0] wdat_q[$];
  logic [3:0]  wstb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          rdy_pct = 100;
  bit          rd_count_mode = 1'b0;
  logic [31:0] rd_seq = 32'd1;
  int          pend = 0;

  logic [31:0] w_addr, r_addr;
  logic [7:0]  w_len, r_len;
  logic [2:0]  w_size, r_size;
  logic [1:0]  w_burst, r_burst;
  logic [0:0]  w_id, r_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Address of beat i of a burst: FIXED stays put, INCR/WRAP step by 2^size modulo 2^32
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i,
                                            input logic [2:0] sz, input logic [1:0] bu);
    logic [31:0] step;
    step = 32'd1 << sz;
    return (bu == 2'b00) ? base : base + step * 32'(i);
  endfunction

  function automatic logic any_out();
    return |{axi_awready_o, axi_wready_o, axi_bvalid_o, axi_bid_o, axi_bresp_o, axi_arready_o,
             axi_rvalid_o, axi_rdata_o, axi_rid_o, axi_rresp_o, axi_rlast_o, iob_valid_o,
             iob_addr_o, iob_wdata_o, iob_wstrb_o};
  endfunction

  // IOb slave: logs requests at mid-cycle, answers reads after 1..3 cycles, random ready
  initial begin
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (arst_i) begin
        pend = 0;
      end else if (iob_valid_o && iob_ready_i) begin
        iob_q.push_back('{addr: iob_addr_o, data: iob_wdata_o, strb: iob_wstrb_o});
        if (iob_wstrb_o == 4'h0) pend = $urandom_range(1, 3);
      end
      @(posedge clk); #1;
      iob_rvalid_i = 1'b0;
      iob_rdata_i  = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          iob_rdata_i  = rd_count_mode ? rd_seq : $urandom;
          rd_seq       = rd_seq + 1;
          iob_rvalid_i = 1'b1;
          exp_r_q.push_back(iob_rdata_i);
        end
      end
      iob_ready_i = ($urandom_range(1, 100) <= rdy_pct);
    end
  end

  task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] b, input logic [0:0] id);
    axi_awaddr_i = a; axi_awlen_i = l; axi_awsize_i = s; axi_awburst_i = b; axi_awid_i = id;
    w_addr = a; w_len = l; w_size = s; w_burst = b; w_id = id;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] b, input logic [0:0] id);
    axi_araddr_i = a; axi_arlen_i = l; axi_arsize_i = s; axi_arburst_i = b; axi_arid_i = id;
    r_addr = a; r_len = l; r_size = s; r_burst = b; r_id = id;
  endtask

  task automatic fill_w(input int nb);
    wdat_q.delete(); wstb_q.delete();
    for (int i = 0; i < nb; i++) begin
      wdat_q.push_back($urandom);
      wstb_q.push_back(4'($urandom_range(1, 15)));
    end
  endtask

  task automatic aw_phase();
    bit ok;
    ok = 1'b0;
    axi_awvalid_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (axi_awready_o) begin ok = 1'b1; break; end
    end
    check("aw_handshake", ok, 1);
    @(posedge clk); #1;
    axi_awvalid_i = 1'b0;
  endtask

  task automatic ar_phase();
    bit ok;
    ok = 1'b0;
    axi_arvalid_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (axi_arready_o) begin ok = 1'b1; break; end
    end
    check("ar_handshake", ok, 1);
    @(posedge clk); #1;
    axi_arvalid_i = 1'b0;
  endtask

  task automatic w_phase();
    bit ok;
    int nb;
    nb = wdat_q.size();
    iob_q.delete();
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      axi_wvalid_i = 1'b1; axi_wdata_i = wdat_q[i]; axi_wstrb_i = wstb_q[i];
      axi_wlast_i  = (i == nb - 1);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (axi_wready_o) begin ok = 1'b1; break; end
      end
      check("w_handshake", ok, 1);
      @(posedge clk); #1;
      axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0; axi_wdata_i = '0; axi_wstrb_i = '0;
      if (!ok) return;
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (axi_bvalid_o) begin ok = 1'b1; break; end
    end
    check("b_valid", ok, 1);
    if (!ok) return;
    check("b_id", axi_bid_o, w_id);
    check("b_resp", axi_bresp_o, 0);
    axi_bready_i = 1'b1;
    @(posedge clk); #1;
    axi_bready_i = 1'b0;
    check("w_iob_count", iob_q.size(), nb);
    for (int i = 0; i < nb && i < iob_q.size(); i++) begin
      check("w_iob_addr", iob_q[i].addr, beat_addr(w_addr, i, w_size, w_burst));
      check("w_iob_data", iob_q[i].data, wdat_q[i]);
      check("w_iob_strb", iob_q[i].strb, wstb_q[i]);
    end
    @(negedge clk);
    check("idle_data_zero", |{iob_wdata_o, iob_wstrb_o, axi_rdata_o, axi_bvalid_o}, 0);
    @(posedge clk); #1;
  endtask

  // stall: cycles rready stays low per beat; cke_drop: clock-enable low with rready high mid-stall
  task automatic r_phase(input int stall, input bit cke_drop);
    bit ok;
    logic [31:0] hold, e;
    iob_q.delete(); exp_r_q.delete();
    for (int i = 0; i <= int'(r_len); i++) begin
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (axi_rvalid_o) begin ok = 1'b1; break; end
      end
      check("r_valid", ok, 1);
      if (!ok) return;
      hold = axi_rdata_o;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        cke_i        = !(cke_drop && s >= 1 && s <= 3);
        axi_rready_i = (cke_drop && s >= 1 && s <= 3);
        @(negedge clk);
        check("r_hold", {axi_rvalid_o, axi_rdata_o}, {1'b1, hold});
      end
      cke_i = 1'b1; axi_rready_i = 1'b0;
      check("r_expected_avail", exp_r_q.size() > 0, 1);
      e = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : 32'h0;
      check("r_data", axi_rdata_o, e);
      check("r_id", axi_rid_o, r_id);
      check("r_resp", axi_rresp_o, 0);
      check("r_last", axi_rlast_o, i == int'(r_len));
      axi_rready_i = 1'b1;
      @(posedge clk); #1;
      axi_rready_i = 1'b0;
    end
    check("r_iob_count", iob_q.size(), int'(r_len) + 1);
    for (int i = 0; i <= int'(r_len) && i < iob_q.size(); i++) begin
      check("r_iob_addr", iob_q[i].addr, beat_addr(r_addr, i, r_size, r_burst));
      check("r_iob_strb", iob_q[i].strb, 0);
    end
    @(negedge clk);
    check("idle_data_zero", |{iob_wdata_o, iob_wstrb_o, axi_rdata_o, axi_rvalid_o}, 0);
    @(posedge clk); #1;
  endtask

  // Both address channels raised together; returns {arready, awready} at first grant
  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (axi_arready_o || axi_awready_o) begin g = {axi_arready_o, axi_awready_o}; break; end
    end
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    cke_i = 1'b1; arst_i = 1'b1;
    axi_awvalid_i = 0; axi_awaddr_i = 0; axi_awid_i = 0; axi_awlen_i = 0; axi_awsize_i = 0;
    axi_awburst_i = 0; axi_wvalid_i = 0; axi_wdata_i = 0; axi_wstrb_i = 0; axi_wlast_i = 0;
    axi_bready_i = 0; axi_arvalid_i = 0; axi_araddr_i = 0; axi_arid_i = 0; axi_arlen_i = 0;
    axi_arsize_i = 0; axi_arburst_i = 0; axi_rready_i = 0;
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;   // valids during reset must not be granted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", any_out(), 0);
    @(posedge clk); #1;
    axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
    arst_i = 1'b0;

    // Contested grant from reset: read first, write next; repeat: write first
    rdy_pct = 100;
    set_aw(32'h500, 0, 2, 1, 1); fill_w(1);
    set_ar(32'h600, 0, 2, 1, 0);
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    wait_grant(g);
    check("arb_first_read", g, 2'b10);
    @(posedge clk); #1; axi_arvalid_i = 1'b0;
    r_phase(0, 0);
    aw_phase(); w_phase();
    set_aw(32'h520, 1, 2, 1, 0); fill_w(2);
    set_ar(32'h620, 1, 2, 1, 1);
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    wait_grant(g);
    check("arb_second_write", g, 2'b01);
    @(posedge clk); #1; axi_awvalid_i = 1'b0;
    w_phase();
    ar_phase(); r_phase(0, 0);

    // Single write of 0xDEADBEEF to 0x100
    set_aw(32'h100, 0, 2, 1, 0);
    wdat_q.delete(); wstb_q.delete();
    wdat_q.push_back(32'hDEADBEEF); wstb_q.push_back(4'hF);
    aw_phase(); w_phase();

    // INCR read burst, slave returns 1..4
    rd_count_mode = 1'b1; rd_seq = 32'd1;
    set_ar(32'h200, 3, 2, 1, 0); ar_phase(); r_phase(0, 0);
    // FIXED read burst
    set_ar(32'h40, 2, 2, 0, 1); ar_phase(); r_phase(1, 0);
    rd_count_mode = 1'b0;

    // Backpressure with clock-enable stall, then address wrap-around
    rdy_pct = 50;
    set_ar(32'h1000, 3, 2, 1, 0); ar_phase(); r_phase(5, 1);
    set_ar(32'hFFFF_FFFC, 1, 2, 1, 1); ar_phase(); r_phase(0, 0);
    set_aw(32'hFFFF_FFF8, 2, 2, 1, 0); fill_w(3); aw_phase(); w_phase();

    // wlast decides burst end regardless of len
    set_aw(32'h700, 3, 2, 1, 1); fill_w(2); aw_phase(); w_phase();
    set_aw(32'h780, 0, 1, 1, 0); fill_w(3); aw_phase(); w_phase();

    // Reset in the middle of beat 2 of a len=7 write
    rdy_pct = 100;
    set_aw(32'h300, 7, 2, 1, 1); aw_phase();
    iob_q.delete();
    axi_wvalid_i = 1'b1; axi_wdata_i = 32'hA5A5_0001; axi_wstrb_i = 4'hF;
    @(negedge clk);
    check("rst_mid_beat1", axi_wready_o, 1);
    @(posedge clk); #1;
    axi_wdata_i = 32'hA5A5_0002; arst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", any_out(), 0);
    check("rst_mid_iob_count", iob_q.size(), 1);
    @(posedge clk); #1;
    arst_i = 1'b0; axi_wvalid_i = 1'b0; axi_wdata_i = '0; axi_wstrb_i = '0;
    set_aw(32'h310, 1, 2, 1, 0); fill_w(2); aw_phase(); w_phase();
    set_ar(32'h310, 0, 2, 1, 1); ar_phase(); r_phase(0, 0);

    // Randomised traffic
    for (int t = 0; t < 24; t++) begin
      logic [2:0]  sz;
      logic [7:0]  ln;
      logic [1:0]  bu;
      logic [31:0] a;
      int          nb;
      sz = 3'($urandom_range(0, 2));
      ln = 8'($urandom_range(0, 5));
      bu = 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | {28'h0, a[3:0]};
      a = a & ~((32'd1 << sz) - 32'd1);
      rdy_pct = $urandom_range(30, 100);
      if ($urandom_range(0, 1) == 1) begin
        nb = ($urandom_range(0, 1) == 1) ? int'(ln) + 1 : $urandom_range(1, int'(ln) + 3);
        set_aw(a, ln, sz, bu, 1'($urandom)); fill_w(nb);
        aw_phase(); w_phase();
      end else begin
        set_ar(a, ln, sz, bu, 1'($urandom));
        ar_phase(); r_phase($urandom_range(0, 2), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
